// File: rtl/note_pkg.sv
// Purpose: shared note word field layout and recorder state encoding (also imported by the sequencer).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package note_pkg;

    // Packed note word layout: [5:0] note, [10:6] len, [14:11] instrument, [15] reserved 0.
    localparam int NOTE_LSB = 0;
    localparam int NOTE_W   = 6;
    localparam int LEN_LSB  = 6;
    localparam int LEN_W    = 5;
    localparam int INST_LSB = 11;
    localparam int INST_W   = 4;
    localparam int WORD_W   = 16;
    localparam int ADDR_W   = 5;

    // Note code 0 means silence; a rest word is all zeros.
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    // Largest length field; a word plays for len+1 strobes, so 32 strobes max.
    localparam logic [LEN_W-1:0]  LEN_MAX   = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_RECORD = 3'd2,
        ST_PAD    = 3'd3,
        ST_DONE   = 3'd4
    } rec_state_t;

endpackage

// File: rtl/note_word_pack.sv
// Purpose: pack {note, len, instrument} into one 16-bit pattern word.
// Latency: combinational.
// Backpressure: none.
module note_word_pack
    import note_pkg::*;
(
    input  logic [NOTE_W-1:0] i_note,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [INST_W-1:0] i_instrument,
    output logic [WORD_W-1:0] o_word
);

    // Place each field at its fixed offset; the top bit stays zero.
    always_comb begin
        o_word                        = '0;
        o_word[NOTE_LSB +: NOTE_W]    = i_note;
        o_word[LEN_LSB  +: LEN_W]     = i_len;
        o_word[INST_LSB +: INST_W]    = i_instrument;
    end

endmodule

// File: rtl/note_recorder.sv
// Purpose: record live note/instrument runs into pattern RAM words at addresses 0..LENGTH (optional NOTE_RECORDER_PAD_EN pads with rests after an early stop).
// Latency: write strobe is registered, one clock after the triggering note strobe or stop.
// Backpressure: none; at most one write per clock, strobes must be at least 2 clocks apart.
module note_recorder
    import note_pkg::*;
#(
    parameter int LENGTH = 15
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_note_stb,
    input  logic                i_arm,
    input  logic                i_stop,
    input  logic [NOTE_W-1:0]   i_note,
    input  logic [INST_W-1:0]   i_instrument,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [WORD_W-1:0]   o_wr_data,
    output logic                o_recording,
    output logic                o_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH);

    rec_state_t          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [NOTE_W-1:0]   r_cap_note;
    logic [INST_W-1:0]   r_cap_inst;
    logic [LEN_W-1:0]    r_count;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic                r_recording;
    logic                r_done;

    rec_state_t          w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [NOTE_W-1:0]   w_cap_note_nxt;
    logic [INST_W-1:0]   w_cap_inst_nxt;
    logic [LEN_W-1:0]    w_count_nxt;
    logic                w_wr_en_nxt;
    logic [ADDR_W-1:0]   w_wr_addr_nxt;
    logic [WORD_W-1:0]   w_wr_data_nxt;
    logic                w_recording_nxt;
    logic                w_done_nxt;

    logic [WORD_W-1:0]   w_cap_word;
    logic                w_live_eq;
    logic                w_at_last;

    // Word for the note currently being held, with its running length.
    note_word_pack u_pack (
        .i_note       (r_cap_note),
        .i_len        (r_count),
        .i_instrument (r_cap_inst),
        .o_word       (w_cap_word)
    );

    assign w_live_eq = (i_note == r_cap_note) && (i_instrument == r_cap_inst);
    assign w_at_last = (r_addr == LAST_ADDR);

    // Next-state, datapath and output decode; stop outranks a coincident strobe.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_cap_note_nxt = r_cap_note;
        w_cap_inst_nxt = r_cap_inst;
        w_count_nxt    = r_count;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_arm) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (i_stop) begin
                    w_state_nxt = ST_DONE;
                end else if (i_note_stb) begin
                    w_cap_note_nxt = i_note;
                    w_cap_inst_nxt = i_instrument;
                    w_count_nxt    = '0;
                    w_state_nxt    = ST_RECORD;
                end
            end

            ST_RECORD: begin
                if (i_stop) begin
                    // Flush the partial run; the strobe in this cycle is dropped.
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_addr;
                    w_wr_data_nxt = w_cap_word;
                    if (w_at_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
`ifdef NOTE_RECORDER_PAD_EN
                        w_state_nxt = ST_PAD;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end
                end else if (i_note_stb) begin
                    if (w_live_eq && (r_count != LEN_MAX)) begin
                        w_count_nxt = r_count + 1'b1;
                    end else begin
                        // Note changed, or a held note filled a 32-strobe word.
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_addr;
                        w_wr_data_nxt = w_cap_word;
                        if (w_at_last) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_addr_nxt     = r_addr + 1'b1;
                            w_cap_note_nxt = i_note;
                            w_cap_inst_nxt = i_instrument;
                            w_count_nxt    = '0;
                        end
                    end
                end
            end

`ifdef NOTE_RECORDER_PAD_EN
            ST_PAD: begin
                // One rest word per clock until the last address is filled.
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_addr;
                w_wr_data_nxt = '0;
                if (w_at_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_addr_nxt = r_addr + 1'b1;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_recording_nxt = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_RECORD) ||
                          (w_state_nxt == ST_PAD);
        // Done trails entry into DONE by a clock, so it rises after the final write.
        w_done_nxt      = (r_state == ST_DONE) && !i_arm;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_cap_note  <= NOTE_REST;
            r_cap_inst  <= '0;
            r_count     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_recording <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_cap_note  <= w_cap_note_nxt;
            r_cap_inst  <= w_cap_inst_nxt;
            r_count     <= w_count_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_recording <= w_recording_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_recording = r_recording;
    assign o_done      = r_done;

endmodule
